// File: rtl/execute_mem_stage_pkg.sv
// execute_mem_stage_pkg: lsu_op encodings, exception causes and the in-flight tracking entry.
package execute_mem_stage_pkg;
    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;
    localparam logic [1:0] LSU_SIZE_D = 2'd3;
    localparam int LSU_UNSIGNED = 2;
    localparam logic [3:0] EXC_LOAD_MISALIGNED = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;

    // offset is sized for XLEN=64; narrower datapaths use its low bits
    typedef struct packed {
        logic       store;
        logic [4:0] waddr;
        logic [2:0] lsu_op;
        logic [2:0] offset;
        logic       kill;
    } mem_track_entry_type;
endpackage

// File: rtl/execute_mem_stage_mem_track_fifo.sv
// mem_track_fifo: in-order queue of outstanding memory requests with a bulk kill.
module mem_track_fifo
    import execute_mem_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       kill_all,
    input  mem_track_entry_type        din,
    output mem_track_entry_type        head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    mem_track_entry_type mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (kill_all)
                for (int i = 0; i < DEPTH; i++) mem[i].kill <= 1'b1;
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/execute_mem_stage.sv
// execute_mem_stage: pipelined load/store issue with in-order response tracking,
// load alignment/extension, misalignment exceptions and flush-with-kill.
module execute_mem_stage
    import execute_mem_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic              iss_store,
    input  logic [2:0]        iss_lsu_op,
    input  logic [XLEN-1:0]   iss_address,
    input  logic [XLEN-1:0]   iss_wdata,
    input  logic [4:0]        iss_waddr,
    input  logic              clear,
    output logic              stall,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [XLEN-1:0]   req_addr,
    output logic              req_wr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [XLEN/8-1:0] req_wstrb,
    input  logic              rsp_valid,
    input  logic [XLEN-1:0]   rsp_rdata,
    output logic              wb_wren,
    output logic [4:0]        wb_waddr,
    output logic [XLEN-1:0]   wb_wdata,
    output logic              exc_valid,
    output logic [3:0]        exc_cause,
    output logic [XLEN-1:0]   exc_tval,
    output logic              busy,
    output logic              rsp_err
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0] size;
    logic [2:0] align_mask;
    logic [7:0] byte_mask;
    logic [OW-1:0] offset;
    logic misaligned, issue_ok, accept, pop, wb_hit, exc_hit;
    logic [CW-1:0] count;
    mem_track_entry_type entry, head;
    logic [XLEN-1:0] rsp_shift, rsp_left, load_data;
    logic [6:0] ext_shift;

    assign size = iss_lsu_op[1:0];
    assign offset = iss_address[OW-1:0];
    assign align_mask = (3'd1 << size) - 3'd1;
    assign misaligned = (|(iss_address[2:0] & align_mask)) | (XLEN == 32 && size == LSU_SIZE_D);
    assign issue_ok = iss_valid & ~clear & ~misaligned;
    // a full queue can still take a new op when the head retires this cycle
    assign req_valid = issue_ok & ((count != CW'(DEPTH)) | rsp_valid);
    assign accept = req_valid & req_ready;
    assign stall = issue_ok & ~accept;
    assign pop = rsp_valid & (count != '0);
    assign busy = count != '0;

    always_comb begin
        byte_mask = size == LSU_SIZE_B ? 8'h01 : size == LSU_SIZE_H ? 8'h03 : size == LSU_SIZE_W ? 8'h0F : 8'hFF;
    end

    assign req_addr = {iss_address[XLEN-1:OW], {OW{1'b0}}};
    assign req_wr = iss_store;
    assign req_wdata = iss_wdata << {offset, 3'b000};
    assign req_wstrb = byte_mask[NB-1:0] << offset;

    assign entry = '{store: iss_store, waddr: iss_waddr, lsu_op: iss_lsu_op, offset: 3'(offset), kill: 1'b0};

    mem_track_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(accept),
        .pop(pop),
        .kill_all(clear),
        .din(entry),
        .head(head),
        .count(count)
    );

    // move the addressed lane to the top, then shift back down with zero or sign fill
    assign rsp_shift = rsp_rdata >> {head.offset[OW-1:0], 3'b000};
    assign ext_shift = 7'(XLEN) - (7'd8 << head.lsu_op[1:0]);
    assign rsp_left = rsp_shift << ext_shift;
    assign load_data = head.lsu_op[LSU_UNSIGNED] ? rsp_left >> ext_shift : $unsigned($signed(rsp_left) >>> ext_shift);

    assign wb_hit = pop & ~clear & ~head.store & ~head.kill & (|head.waddr);
    assign exc_hit = iss_valid & ~clear & misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wren <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
            exc_valid <= 1'b0;
            exc_cause <= '0;
            exc_tval <= '0;
            rsp_err <= 1'b0;
        end else begin
            wb_wren <= wb_hit;
            if (wb_hit) begin
                wb_waddr <= head.waddr;
                wb_wdata <= load_data;
            end
            exc_valid <= exc_hit;
            if (exc_hit) begin
                exc_cause <= iss_store ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
                exc_tval <= iss_address;
            end
            if (rsp_valid & (count == '0)) rsp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_execute_mem_stage.sv
// tb_execute_mem_stage: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_execute_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_store, clear, req_ready, rsp_valid;
    logic [2:0]  iss_lsu_op;
    logic [31:0] iss_address, iss_wdata, rsp_rdata;
    logic [4:0]  iss_waddr;
    logic        stall, req_valid, req_wr, wb_wren, exc_valid, busy, rsp_err;
    logic [31:0] req_addr, req_wdata, wb_wdata, exc_tval;
    logic [3:0]  req_wstrb, exc_cause;
    logic [4:0]  wb_waddr;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit        st;
        bit [4:0]  wa;
        bit [2:0]  op;
        bit [31:0] addr;
        bit        kill;
    } ent_t;
    ent_t q[$];

    execute_mem_stage #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_store(iss_store), .iss_lsu_op(iss_lsu_op),
        .iss_address(iss_address), .iss_wdata(iss_wdata), .iss_waddr(iss_waddr),
        .clear(clear), .stall(stall),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wb_wren(wb_wren), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .busy(busy), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_store = 0; iss_lsu_op = 0; iss_address = 0; iss_wdata = 0;
        iss_waddr = 0; clear = 0; req_ready = 1; rsp_valid = 0; rsp_rdata = 0;
    endtask

    task automatic issue(input bit st, input bit [2:0] op, input bit [31:0] a, input bit [31:0] wd, input bit [4:0] wa);
        iss_valid = 1; iss_store = st; iss_lsu_op = op; iss_address = a; iss_wdata = wd; iss_waddr = wa;
    endtask

    // byte-by-byte extraction with explicit sign fill
    function automatic logic [31:0] ref_load(logic [31:0] rd, int off, int bytes, bit uns);
        longint unsigned v = 0;
        for (int i = 0; i < bytes; i++)
            v |= (longint'(rd >> ((off + i) * 8)) & 64'hFF) << (i * 8);
        if (!uns && ((v >> (bytes * 8 - 1)) & 1) != 0)
            v |= ~((64'd1 << (bytes * 8)) - 1);
        return v[31:0];
    endfunction

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (wb_wren !== 1'b0 || wb_wdata !== 32'h0 || wb_waddr !== 5'h0) begin n_fail++; $display("FAIL reset_wb: got %b/%h/%h expected 0", wb_wren, wb_waddr, wb_wdata); end
        n_cmp++; if (exc_valid !== 1'b0 || exc_cause !== 4'h0 || exc_tval !== 32'h0) begin n_fail++; $display("FAIL reset_exc: got %b/%h/%h expected 0", exc_valid, exc_cause, exc_tval); end
        n_cmp++; if (rsp_err !== 1'b0 || stall !== 1'b0 || req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_misc: err %b stall %b rv %b expected 0", rsp_err, stall, req_valid); end
    endtask

    task automatic test_load_words();
        bit [2:0]  ops [3] = '{3'b000, 3'b001, 3'b101};
        bit [31:0] adr [3] = '{32'h1001, 32'h1002, 32'h1002};
        bit [31:0] exp [3] = '{32'h0000007F, 32'hFFFF80FF, 32'h000080FF};
        for (int i = 0; i < 3; i++) begin
            idle();
            issue(0, ops[i], adr[i], 0, 5'd3 + 5'(i));
            #1;
            n_cmp++; if (req_valid !== 1'b1 || req_wr !== 1'b0 || req_addr !== 32'h1000 || stall !== 1'b0) begin n_fail++; $display("FAIL load_req%0d: rv %b wr %b addr %h stall %b expected 1 0 00001000 0", i, req_valid, req_wr, req_addr, stall); end
            tick();
            idle();
            rsp_valid = 1; rsp_rdata = 32'h80FF7F01;
            tick();
            n_cmp++; if (wb_wren !== 1'b1 || wb_waddr !== 5'd3 + 5'(i) || wb_wdata !== exp[i]) begin n_fail++; $display("FAIL load_wb%0d: got %b/%0d/%h expected 1/%0d/%h", i, wb_wren, wb_waddr, wb_wdata, 3 + i, exp[i]); end
            rsp_valid = 0;
            tick();
            n_cmp++; if (wb_wren !== 1'b0 || wb_wdata !== exp[i]) begin n_fail++; $display("FAIL load_pulse%0d: got %b/%h expected 0/%h", i, wb_wren, wb_wdata, exp[i]); end
        end
    endtask

    task automatic test_store_lanes();
        idle();
        issue(1, 3'b000, 32'h2003, 32'h000000AB, 0);
        #1;
        n_cmp++; if (req_valid !== 1'b1 || req_wr !== 1'b1 || req_wstrb !== 4'b1000 || req_wdata !== 32'hAB000000 || req_addr !== 32'h2000) begin n_fail++; $display("FAIL store_sb: rv %b wr %b strb %b data %h addr %h", req_valid, req_wr, req_wstrb, req_wdata, req_addr); end
        tick();
        idle();
        rsp_valid = 1;
        tick();
        n_cmp++; if (wb_wren !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL store_ack: wren %b busy %b expected 0 0", wb_wren, busy); end
        idle();
        issue(1, 3'b001, 32'h2001, 32'h1234, 0);
        #1;
        n_cmp++; if (req_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL store_mis_req: rv %b stall %b expected 0 0", req_valid, stall); end
        tick();
        idle();
        n_cmp++; if (exc_valid !== 1'b1 || exc_cause !== 4'd6 || exc_tval !== 32'h2001 || busy !== 1'b0) begin n_fail++; $display("FAIL store_mis_exc: got %b/%0d/%h busy %b expected 1/6/00002001 0", exc_valid, exc_cause, exc_tval, busy); end
        tick();
        n_cmp++; if (exc_valid !== 1'b0) begin n_fail++; $display("FAIL exc_pulse: got %b expected 0", exc_valid); end
    endtask

    task automatic test_full_queue();
        idle();
        for (int i = 0; i < 4; i++) begin
            issue(0, 3'b010, 32'h100 + 32'(4 * i), 0, 5'(i + 1));
            tick();
        end
        issue(0, 3'b010, 32'h200, 0, 5'd5);
        #1;
        n_cmp++; if (busy !== 1'b1 || stall !== 1'b1 || req_valid !== 1'b0) begin n_fail++; $display("FAIL full_stall: busy %b stall %b rv %b expected 1 1 0", busy, stall, req_valid); end
        tick();
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_hold: stall %b expected 1", stall); end
        rsp_valid = 1; rsp_rdata = 32'hC0DE0001;
        #1;
        n_cmp++; if (stall !== 1'b0 || req_valid !== 1'b1) begin n_fail++; $display("FAIL full_accept: stall %b rv %b expected 0 1", stall, req_valid); end
        tick();
        iss_valid = 0;
        n_cmp++; if (wb_wren !== 1'b1 || wb_waddr !== 5'd1 || wb_wdata !== 32'hC0DE0001) begin n_fail++; $display("FAIL full_wb1: got %b/%0d/%h expected 1/1/c0de0001", wb_wren, wb_waddr, wb_wdata); end
        for (int i = 2; i <= 5; i++) begin
            rsp_rdata = 32'hC0DE0000 + 32'(i);
            tick();
            n_cmp++; if (wb_wren !== 1'b1 || wb_waddr !== 5'(i) || wb_wdata !== 32'hC0DE0000 + 32'(i)) begin n_fail++; $display("FAIL full_wb%0d: got %b/%0d/%h", i, wb_wren, wb_waddr, wb_wdata); end
        end
        rsp_valid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL full_drain: busy %b err %b expected 0 0", busy, rsp_err); end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) begin
            issue(0, 3'b010, 32'h300 + 32'(4 * i), 0, 5'(10 + i));
            tick();
        end
        idle();
        clear = 1;
        tick();
        clear = 0;
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1; rsp_rdata = $urandom;
            tick();
            n_cmp++; if (wb_wren !== 1'b0) begin n_fail++; $display("FAIL flush_kill%0d: wren %b expected 0", i, wb_wren); end
        end
        rsp_valid = 0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_drain: busy %b expected 0", busy); end
        issue(0, 3'b010, 32'h40, 0, 5'd5);
        tick();
        idle();
        rsp_valid = 1; rsp_rdata = 32'h12345678;
        tick();
        rsp_valid = 0;
        n_cmp++; if (wb_wren !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'h12345678) begin n_fail++; $display("FAIL flush_after: got %b/%0d/%h expected 1/5/12345678", wb_wren, wb_waddr, wb_wdata); end
    endtask

    task automatic test_error_reset();
        idle();
        rsp_valid = 1;
        tick();
        rsp_valid = 0;
        n_cmp++; if (rsp_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_set: err %b busy %b expected 1 0", rsp_err, busy); end
        tick(); tick();
        n_cmp++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err %b expected 1", rsp_err); end
        issue(0, 3'b010, 32'h500, 0, 5'd7);
        tick();
        issue(0, 3'b010, 32'h504, 0, 5'd8);
        tick();
        idle();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL err_inflight: busy %b expected 1", busy); end
        rsp_valid = 1; rsp_rdata = 32'hFFFFFFFF;
        rst = 1;
        tick();
        rst = 0;
        rsp_valid = 0;
        n_cmp++; if (busy !== 1'b0 || rsp_err !== 1'b0 || wb_wren !== 1'b0) begin n_fail++; $display("FAIL err_reset: busy %b err %b wren %b expected 0 0 0", busy, rsp_err, wb_wren); end
    endtask

    task automatic test_random();
        q.delete();
        idle();
        for (int c = 0; c < 600; c++) begin
            int sz, bytes, off;
            bit mis, ok, full, exp_rv, acc, wbe, exc_e;
            bit [4:0] exp_wa;
            bit [31:0] exp_wd, exp_data;
            bit [3:0] exp_strb, exp_cause;
            bit [31:0] exp_tval;
            ent_t h;
            iss_valid = $urandom_range(0, 3) != 0;
            iss_store = $urandom_range(0, 2) == 0;
            iss_lsu_op = {1'($urandom), ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2))};
            sz = int'(iss_lsu_op[1:0]);
            bytes = 1 << sz;
            iss_address = $urandom;
            if ($urandom_range(0, 3) != 0) iss_address = iss_address - (iss_address % 32'(bytes));
            iss_wdata = $urandom;
            iss_waddr = 5'($urandom_range(0, 31));
            clear = $urandom_range(0, 19) == 0;
            req_ready = $urandom_range(0, 3) != 0;
            rsp_valid = q.size() > 0 && $urandom_range(0, 2) != 0;
            rsp_rdata = $urandom;
            off = int'(iss_address % 4);
            mis = sz == 3 || (iss_address % 32'(bytes)) != 0;
            ok = iss_valid && !clear && !mis;
            full = q.size() == 4;
            exp_rv = ok && (!full || rsp_valid);
            acc = exp_rv && req_ready;
            #1;
            n_cmp++; if (req_valid !== exp_rv || stall !== (ok && !acc)) begin n_fail++; $display("FAIL rnd_issue c%0d: rv %b stall %b expected %b %b", c, req_valid, stall, exp_rv, ok && !acc); end
            if (exp_rv) begin
                exp_strb = 0;
                for (int b = 0; b < 4; b++) exp_strb[b] = b >= off && b < off + bytes;
                exp_wd = 32'(64'(iss_wdata) * (64'd1 << (8 * off)));
                n_cmp++; if (req_addr !== iss_address - 32'(off) || req_wr !== iss_store || (iss_store && (req_wstrb !== exp_strb || req_wdata !== exp_wd))) begin n_fail++; $display("FAIL rnd_req c%0d: addr %h wr %b strb %b data %h expected %h %b %b %h", c, req_addr, req_wr, req_wstrb, req_wdata, iss_address - 32'(off), iss_store, exp_strb, exp_wd); end
            end
            wbe = 0; exp_wa = 0; exp_data = 0;
            if (rsp_valid) begin
                h = q.pop_front();
                wbe = !h.st && !h.kill && !clear && h.wa != 0;
                exp_wa = h.wa;
                exp_data = ref_load(rsp_rdata, int'(h.addr % 4), 1 << h.op[1:0], h.op[2]);
            end
            if (clear) foreach (q[i]) q[i].kill = 1;
            if (acc) q.push_back('{st: iss_store, wa: iss_waddr, op: iss_lsu_op, addr: iss_address, kill: 0});
            exc_e = iss_valid && !clear && mis;
            exp_cause = iss_store ? 4'd6 : 4'd4;
            exp_tval = iss_address;
            tick();
            n_cmp++; if (wb_wren !== wbe || (wbe && (wb_waddr !== exp_wa || wb_wdata !== exp_data))) begin n_fail++; $display("FAIL rnd_wb c%0d: got %b/%0d/%h expected %b/%0d/%h", c, wb_wren, wb_waddr, wb_wdata, wbe, exp_wa, exp_data); end
            n_cmp++; if (exc_valid !== exc_e || (exc_e && (exc_cause !== exp_cause || exc_tval !== exp_tval))) begin n_fail++; $display("FAIL rnd_exc c%0d: got %b/%0d/%h expected %b/%0d/%h", c, exc_valid, exc_cause, exc_tval, exc_e, exp_cause, exp_tval); end
            n_cmp++; if (busy !== (q.size() != 0) || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rnd_busy c%0d: busy %b err %b expected %b 0", c, busy, rsp_err, q.size() != 0); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_words();
        test_store_lanes();
        test_full_queue();
        test_flush();
        test_error_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
